// File: rtl/em_sched.sv
// Edge-memory scheduler: fills the edge memory from the channel, then runs a fixed-length decode.
// Optional macro EM_SCHED_HOLD_CNT_EN adds a saturating HOLD_CNT output counting held decode cycles.
module em_sched #(
  parameter int N       = 8,
  parameter int LOGN    = 3,
  parameter int DEC_CYC = 256
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            ABORT,
  input  logic            HOLD,
  input  logic            LLR_BIT,
  input  logic            VN_BIT,
  input  logic [LOGN-1:0] RAND,
  input  logic            EM_OUT,
  output logic            EM_EN,
  output logic            EM_IN,
  output logic [N-1:0]    EM_SEL,
  output logic            EDGE_OUT,
  output logic            BUSY,
  output logic            DONE,
  output logic [15:0]     CYC_CNT,
`ifdef EM_SCHED_HOLD_CNT_EN
  output logic [15:0]     HOLD_CNT,
`endif
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_DECODE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [15:0] FILL_LAST = 16'(N - 1);
  localparam logic [15:0] DEC_LAST  = 16'(DEC_CYC - 1);
  localparam logic [LOGN:0] N_W     = (LOGN + 1)'(N);

  state_t        state, next_state;
  logic   [15:0] next_cnt;
  logic [LOGN:0] rand_ext, sel_idx;

  assign state_dbg = state;

  // Next state, counter and the zero-latency edge-memory controls.
  always_comb begin
    next_state = state;
    next_cnt   = CYC_CNT;
    EM_EN      = 1'b0;
    EM_IN      = 1'b0;
    EDGE_OUT   = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          next_state = S_FILL;
          next_cnt   = 16'd0;
        end
      end
      S_FILL: begin
        EM_EN    = 1'b1;
        EM_IN    = LLR_BIT;
        EDGE_OUT = LLR_BIT;
        if (CYC_CNT == FILL_LAST) begin
          next_state = S_DECODE;
          next_cnt   = 16'd0;
        end else begin
          next_cnt = CYC_CNT + 16'd1;
        end
      end
      S_DECODE: begin
        EM_EN    = ~HOLD;
        EM_IN    = VN_BIT;
        EDGE_OUT = HOLD ? EM_OUT : VN_BIT;
        // A held cycle still consumes decode time; the count stops at its last value.
        if (CYC_CNT == DEC_LAST) begin
          next_state = S_FINISH;
        end else begin
          next_cnt = CYC_CNT + 16'd1;
        end
      end
      S_FINISH: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (ABORT) begin
      next_state = S_IDLE;
      next_cnt   = 16'd0;
    end
  end

  // RAND can exceed N-1 when N is not a power of two; fold it back once.
  assign rand_ext = {1'b0, RAND};
  assign sel_idx  = (rand_ext >= N_W) ? (rand_ext - N_W) : rand_ext;

  always_comb begin
    EM_SEL = '0;
    for (int i = 0; i < N; i++) begin
      EM_SEL[i] = (sel_idx == (LOGN + 1)'(i));
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      CYC_CNT <= 16'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= next_state;
      CYC_CNT <= next_cnt;
      BUSY    <= (next_state == S_FILL) || (next_state == S_DECODE);
      DONE    <= (next_state == S_FINISH);
    end
  end

`ifdef EM_SCHED_HOLD_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HOLD_CNT <= 16'd0;
    end else if (state == S_FILL && next_state == S_DECODE) begin
      HOLD_CNT <= 16'd0;
    end else if (state == S_DECODE && HOLD && HOLD_CNT != 16'hFFFF) begin
      HOLD_CNT <= HOLD_CNT + 16'd1;
    end
  end
`endif

endmodule
